// File: rtl/multicycle_controller.sv
// Multicycle control unit for a small RV64 subset (add/sub/and/or/addi/ld/sd/beq).
// A six-state FSM sequences each instruction; strobes are decoded from state and the latched IR.
module multicycle_controller #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                        alu_zero,
  output logic                        ir_load,
  output logic                        pc_en,
  output logic                        pc_sel,
  output logic [4:0]                  rf_addr_a,
  output logic [4:0]                  rf_addr_b,
  output logic [4:0]                  rf_write_addr,
  output logic                        rf_write_en,
  output logic [WORDSIZE-1:0]         immediate,
  output logic                        mux_0_sel,
  output logic                        mux_1_sel,
  output logic                        mux_2_sel,
  output logic [2:0]                  alu_operation,
  output logic                        dm_write_en,
  output logic [2:0]                  state,
  output logic                        trap
);

  typedef enum logic [2:0] {
    FETCH     = 3'b000,
    DECODE    = 3'b001,
    EXECUTE   = 3'b010,
    MEMORY    = 3'b011,
    WRITEBACK = 3'b100,
    TRAP      = 3'b101
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_ADDI,
    OP_LD,
    OP_SD,
    OP_BEQ,
    OP_ILLEGAL
  } op_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_t      current_state;
  logic [31:0] ir;
  op_t         op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign rf_addr_a     = ir[19:15];
  assign rf_addr_b     = ir[24:20];
  assign rf_write_addr = rd;
  assign state         = current_state;

  // Instruction classification from the latched IR; anything not matched exactly is illegal.
  always_comb begin
    op = OP_ILLEGAL;
    case (opcode)
      OPC_RTYPE: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      op = OP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) op = OP_SUB;
        else if (funct3 == 3'b111 && funct7 == 7'b0000000) op = OP_AND;
        else if (funct3 == 3'b110 && funct7 == 7'b0000000) op = OP_OR;
      end
      OPC_OPIMM:  if (funct3 == 3'b000) op = OP_ADDI;
      OPC_LOAD:   if (funct3 == 3'b011) op = OP_LD;
      OPC_STORE:  if (funct3 == 3'b011) op = OP_SD;
      OPC_BRANCH: if (funct3 == 3'b000) op = OP_BEQ;
      default:    op = OP_ILLEGAL;
    endcase
  end

  always_comb begin
    immediate = '0;
    case (op)
      OP_ADDI, OP_LD: immediate = {{(WORDSIZE-12){ir[31]}}, ir[31:20]};
      OP_SD:          immediate = {{(WORDSIZE-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BEQ:         immediate = {{(WORDSIZE-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:        immediate = '0;
    endcase
  end

  // ALU steering for the current instruction; only driven out in the ALU-using states.
  logic       b_from_rf;
  logic [2:0] alu_code;

  always_comb begin
    b_from_rf = 1'b0;
    alu_code  = ALU_ADD;
    case (op)
      OP_ADD:  begin b_from_rf = 1'b1; alu_code = ALU_ADD; end
      OP_SUB:  begin b_from_rf = 1'b1; alu_code = ALU_SUB; end
      OP_AND:  begin b_from_rf = 1'b1; alu_code = ALU_AND; end
      OP_OR:   begin b_from_rf = 1'b1; alu_code = ALU_OR;  end
      OP_BEQ:  begin b_from_rf = 1'b1; alu_code = ALU_SUB; end
      default: begin b_from_rf = 1'b0; alu_code = ALU_ADD; end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_state <= FETCH;
      ir            <= '0;
    end else begin
      case (current_state)
        FETCH: begin
          ir            <= instruction[31:0];
          current_state <= DECODE;
        end
        DECODE:
          current_state <= (op == OP_ILLEGAL) ? TRAP : EXECUTE;
        EXECUTE: begin
          case (op)
            OP_BEQ:                          current_state <= FETCH;
            OP_LD, OP_SD:                    current_state <= MEMORY;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI:                         current_state <= WRITEBACK;
            default:                         current_state <= TRAP;
          endcase
        end
        MEMORY: begin
          if (op == OP_LD)      current_state <= WRITEBACK;
          else if (op == OP_SD) current_state <= FETCH;
          else                  current_state <= TRAP;
        end
        WRITEBACK: current_state <= FETCH;
        TRAP:      current_state <= TRAP;
        default:   current_state <= TRAP;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    ir_load       = 1'b0;
    pc_en         = 1'b0;
    pc_sel        = 1'b0;
    rf_write_en   = 1'b0;
    mux_0_sel     = 1'b0;
    mux_1_sel     = 1'b0;
    mux_2_sel     = 1'b0;
    alu_operation = ALU_ADD;
    dm_write_en   = 1'b0;
    trap          = 1'b0;
    case (current_state)
      FETCH:  ir_load = 1'b1;
      DECODE: ;
      EXECUTE: begin
        mux_1_sel     = b_from_rf;
        alu_operation = alu_code;
        if (op == OP_BEQ) begin
          pc_en  = 1'b1;
          pc_sel = alu_zero;
        end
      end
      MEMORY: begin
        mux_1_sel     = b_from_rf;
        alu_operation = alu_code;
        if (op == OP_SD) begin
          dm_write_en = 1'b1;
          pc_en       = 1'b1;
        end
      end
      WRITEBACK: begin
        // ALU steering is held so an unregistered alu_result stays valid for writeback.
        mux_1_sel     = b_from_rf;
        alu_operation = alu_code;
        mux_2_sel     = (op == OP_LD);
        rf_write_en   = (rd != 5'd0);
        pc_en         = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction cases plus random legal
// instructions compared against an instruction-level model of phases, fields and immediates.
module tb_multicycle_controller;

  localparam int WS = 64;
  localparam int S_FETCH = 0, S_DECODE = 1, S_EXECUTE = 2, S_MEMORY = 3, S_WRITEBACK = 4, S_TRAP = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   instruction = '0;
  logic          alu_zero = 1'b0;
  logic          ir_load, pc_en, pc_sel, rf_write_en, mux_0_sel, mux_1_sel, mux_2_sel;
  logic          dm_write_en, trap;
  logic [4:0]    rf_addr_a, rf_addr_b, rf_write_addr;
  logic [WS-1:0] immediate;
  logic [2:0]    alu_operation, state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_word = '0;

  always #5 clk = ~clk;

  multicycle_controller #(.WORDSIZE(WS), .INSTRUCTION_SIZE(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .alu_zero(alu_zero),
    .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_write_addr(rf_write_addr),
    .rf_write_en(rf_write_en), .immediate(immediate),
    .mux_0_sel(mux_0_sel), .mux_1_sel(mux_1_sel), .mux_2_sel(mux_2_sel),
    .alu_operation(alu_operation), .dm_write_en(dm_write_en), .state(state), .trap(trap)
  );

  typedef enum int {C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_LD, C_SD, C_BEQ, C_ILL} cls_t;

  function automatic cls_t classify(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    if (opc == 7'b0110011 && f3 == 3'd0 && f7 == 7'h00) return C_ADD;
    if (opc == 7'b0110011 && f3 == 3'd0 && f7 == 7'h20) return C_SUB;
    if (opc == 7'b0110011 && f3 == 3'd7 && f7 == 7'h00) return C_AND;
    if (opc == 7'b0110011 && f3 == 3'd6 && f7 == 7'h00) return C_OR;
    if (opc == 7'b0010011 && f3 == 3'd0) return C_ADDI;
    if (opc == 7'b0000011 && f3 == 3'd3) return C_LD;
    if (opc == 7'b0100011 && f3 == 3'd3) return C_SD;
    if (opc == 7'b1100011 && f3 == 3'd0) return C_BEQ;
    return C_ILL;
  endfunction

  // Immediates rebuilt with signed arithmetic rather than bit concatenation.
  function automatic longint expected_imm(input logic [31:0] w, input cls_t c);
    longint sw;
    sw = longint'($signed(w));
    case (c)
      C_ADDI, C_LD: return sw >>> 20;
      C_SD:         return (sw >>> 25) * 32 + longint'(w[11:7]);
      C_BEQ:        return (sw >>> 31) * 4096 + longint'(w[7]) * 2048
                           + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [2:0] expected_alu(input cls_t c);
    case (c)
      C_SUB, C_BEQ: return 3'b001;
      C_AND:        return 3'b010;
      C_OR:         return 3'b011;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 7);
    case (k)
      0: begin w[6:0] = 7'b0110011; w[14:12] = 3'd0; w[31:25] = 7'h00; end
      1: begin w[6:0] = 7'b0110011; w[14:12] = 3'd0; w[31:25] = 7'h20; end
      2: begin w[6:0] = 7'b0110011; w[14:12] = 3'd7; w[31:25] = 7'h00; end
      3: begin w[6:0] = 7'b0110011; w[14:12] = 3'd6; w[31:25] = 7'h00; end
      4: begin w[6:0] = 7'b0010011; w[14:12] = 3'd0; end
      5: begin w[6:0] = 7'b0000011; w[14:12] = 3'd3; end
      6: begin w[6:0] = 7'b0100011; w[14:12] = 3'd3; end
      default: begin w[6:0] = 7'b1100011; w[14:12] = 3'd0; end
    endcase
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (instr %08h): observed %0h expected %0h", tag, cur_word, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (instr %08h): observed %0b expected %0b", tag, cur_word, obs, exp);
    end
  endtask

  // Asserts rst between edges, checks the immediate reset effect, then releases mid-high-phase.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_state", 64'(state), 64'(S_FETCH));
    check_bit("rst_ir_load", ir_load, 1'b1);
    check_bit("rst_trap", trap, 1'b0);
    check_bit("rst_pc_en", pc_en, 1'b0);
    check_bit("rst_rf_write_en", rf_write_en, 1'b0);
    check_bit("rst_dm_write_en", dm_write_en, 1'b0);
    check("rst_immediate", immediate, 64'd0);
    check("rst_rf_write_addr", 64'(rf_write_addr), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] word, input logic az);
    cls_t   c;
    longint imm;
    bit     mem, wb, uses_rs2;
    int     n, kind, pc_pulses, rf_pulses, dm_pulses;
    c         = classify(word);
    imm       = expected_imm(word, c);
    mem       = (c == C_LD) || (c == C_SD);
    wb        = (c != C_SD) && (c != C_BEQ);
    uses_rs2  = c inside {C_ADD, C_SUB, C_AND, C_OR, C_BEQ};
    n         = 3 + int'(mem) + int'(wb);
    pc_pulses = 0;
    rf_pulses = 0;
    dm_pulses = 0;
    cur_word  = word;
    for (int p = 0; p < n; p++) begin
      kind = (p < 3) ? p : ((p == 3 && mem) ? S_MEMORY : S_WRITEBACK);
      @(negedge clk);
      instruction = (kind == S_FETCH) ? word : $urandom;
      alu_zero    = az;
      #1;
      check("state", 64'(state), 64'(kind));
      pc_pulses += int'(pc_en);
      rf_pulses += int'(rf_write_en);
      dm_pulses += int'(dm_write_en);
      case (kind)
        S_FETCH: begin
          check_bit("fetch_ir_load", ir_load, 1'b1);
          check_bit("fetch_pc_en", pc_en, 1'b0);
          check_bit("fetch_trap", trap, 1'b0);
        end
        S_DECODE: begin
          check_bit("decode_ir_load", ir_load, 1'b0);
          check_bit("decode_pc_en", pc_en, 1'b0);
          check_bit("decode_trap", trap, 1'b0);
          check("rf_addr_a", 64'(rf_addr_a), 64'(word[19:15]));
          check("rf_addr_b", 64'(rf_addr_b), 64'(word[24:20]));
          check("rf_write_addr", 64'(rf_write_addr), 64'(word[11:7]));
          check("decode_immediate", immediate, imm);
        end
        S_EXECUTE: begin
          check_bit("exec_mux_0_sel", mux_0_sel, 1'b0);
          check_bit("exec_mux_1_sel", mux_1_sel, uses_rs2);
          check("exec_alu_operation", 64'(alu_operation), 64'(expected_alu(c)));
          check("exec_immediate", immediate, imm);
          check_bit("exec_pc_en", pc_en, c == C_BEQ);
          check_bit("exec_pc_sel", pc_sel, (c == C_BEQ) && az);
          check_bit("exec_dm_write_en", dm_write_en, 1'b0);
          if (c == C_BEQ) begin
            alu_zero = ~az;
            #1;
            check_bit("exec_pc_sel_follows_zero", pc_sel, ~az);
            alu_zero = az;
          end
        end
        S_MEMORY: begin
          check_bit("mem_mux_1_sel", mux_1_sel, uses_rs2);
          check("mem_alu_operation", 64'(alu_operation), 64'(expected_alu(c)));
          check_bit("mem_dm_write_en", dm_write_en, c == C_SD);
          check_bit("mem_pc_en", pc_en, c == C_SD);
          check_bit("mem_pc_sel", pc_sel, 1'b0);
          check_bit("mem_rf_write_en", rf_write_en, 1'b0);
        end
        default: begin
          check_bit("wb_rf_write_en", rf_write_en, word[11:7] != 5'd0);
          check_bit("wb_mux_2_sel", mux_2_sel, c == C_LD);
          check_bit("wb_pc_en", pc_en, 1'b1);
          check_bit("wb_pc_sel", pc_sel, 1'b0);
          check_bit("wb_dm_write_en", dm_write_en, 1'b0);
        end
      endcase
    end
    check("pc_en_pulses", 64'(pc_pulses), 64'd1);
    check("rf_write_pulses", 64'(rf_pulses), 64'(wb && (word[11:7] != 5'd0)));
    check("dm_write_pulses", 64'(dm_pulses), 64'(c == C_SD));
  endtask

  // Illegal word: FETCH, DECODE, then ten cycles parked in TRAP with strobes low; ends in reset.
  task automatic run_illegal(input logic [31:0] word);
    cur_word = word;
    @(negedge clk);
    instruction = word;
    #1;
    check("ill_fetch_state", 64'(state), 64'(S_FETCH));
    @(negedge clk);
    instruction = $urandom;
    #1;
    check("ill_decode_state", 64'(state), 64'(S_DECODE));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instruction = $urandom;
      #1;
      check("trap_state", 64'(state), 64'(S_TRAP));
      check_bit("trap_flag", trap, 1'b1);
      check_bit("trap_ir_load", ir_load, 1'b0);
      check_bit("trap_pc_en", pc_en, 1'b0);
      check_bit("trap_rf_write_en", rf_write_en, 1'b0);
      check_bit("trap_dm_write_en", dm_write_en, 1'b0);
    end
    do_reset();
  endtask

  // sd aborted by reset while its data-memory write strobe is active.
  task automatic run_sd_abort(input logic [31:0] word);
    cur_word = word;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      instruction = (p == 0) ? word : $urandom;
      #1;
      check("abort_state", 64'(state), 64'(p));
    end
    check_bit("abort_dm_before_rst", dm_write_en, 1'b1);
    do_reset();
  endtask

  initial begin
    logic [31:0] w;
    #1;
    cur_word = '0;
    do_reset();

    run_instr(32'h00500093, 1'b0);   // addi x1,x0,5
    run_instr(32'h002081B3, 1'b0);   // add x3,x1,x2
    run_instr(32'h00813283, 1'b0);   // ld x5,8(x2)
    run_instr(32'h00513823, 1'b0);   // sd x5,16(x2)
    run_instr(32'hFE208CE3, 1'b1);   // beq x1,x2,-8 taken
    run_instr(32'hFE208CE3, 1'b0);   // beq not taken

    for (int i = 0; i < 40; i++) begin
      w = gen_legal();
      run_instr(w, 1'($urandom_range(0, 1)));
    end

    run_illegal(32'hFFFFFFFF);
    run_instr(32'h00100013, 1'b0);   // addi x0,x0,1: no register write
    run_illegal(32'h00101093);       // opcode OP-IMM with funct3 001
    run_illegal(32'h00812283);       // LOAD with funct3 010
    for (int i = 0; i < 3; i++) begin
      w = 32'hFFFFFFFF;
      for (int t = 0; t < 100; t++) begin
        w = $urandom;
        if (classify(w) == C_ILL) break;
      end
      if (classify(w) != C_ILL) w = 32'hFFFFFFFF;
      run_illegal(w);
    end

    run_sd_abort(32'h00513823);
    run_instr(32'h002081B3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, meaning datapath word width and immediate output width.
REQ-002 SHALL have parameter INSTRUCTION_SIZE, default 32, meaning instruction width.
REQ-003 SHALL have ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  INSTRUCTION_SIZE  instruction memory output for current PC.
- alu_zero  input  1  high when alu_result == 0.
- ir_load  output  1  instruction register captures instruction this cycle.
- pc_en  output  1  program counter updates at the next edge.
- pc_sel  output  1  0 = PC+4, 1 = PC+immediate.
- rf_addr_a, rf_addr_b, rf_write_addr  output  5 each  rs1, rs2, rd from the latched instruction.
- rf_write_en  output  1  register file write strobe.
- immediate  output  WORDSIZE  sign-extended immediate.
- mux_0_sel  output  1  0 = rf_data_a to ALU A, 1 = rf_data_b.
- mux_1_sel  output  1  0 = immediate to ALU B, 1 = rf_data_b.
- mux_2_sel  output  1  0 = alu_result to writeback, 1 = dm_data_output.
- alu_operation  output  3  000 add, 001 sub, 010 and, 011 or.
- dm_write_en  output  1  data memory write strobe.
- state  output  3  current FSM state encoding.
- trap  output  1  illegal instruction detected; core halted.

Function
REQ-004 SHALL implement states FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, TRAP=101; unused encodings SHALL go to TRAP.
REQ-005 FETCH: ir_load=1; 32-bit IR captures instruction on the edge; next state DECODE.
REQ-006 DECODE: classify the latched IR: R-type (opcode 0110011, funct3/funct7 add 000/0000000, sub 000/0100000, and 111/0000000, or 110/0000000), addi (0010011, funct3 000), ld (0000011, funct3 011), sd (0100011, funct3 011), beq (1100011, funct3 000); any other encoding -> TRAP, else EXECUTE.
REQ-007 Immediate SHALL be sign-extended from bit 31 to WORDSIZE: I-format for addi/ld, S-format for sd, B-format (bit 0 = 0) for beq, 0 for R-type; valid from DECODE onward.
REQ-008 EXECUTE: mux_0_sel=0; mux_1_sel=1 for R-type and beq, else 0; alu_operation = sub for beq, per funct for R-type, add otherwise.
REQ-009 EXECUTE transitions: R-type/addi -> WRITEBACK; ld/sd -> MEMORY; beq -> FETCH with pc_en=1 and pc_sel=alu_zero.
REQ-010 MEMORY: ALU controls held as in EXECUTE; sd asserts dm_write_en=1 for exactly this cycle, pc_en=1, pc_sel=0, next FETCH; ld -> WRITEBACK.
REQ-011 WRITEBACK: rf_write_en=1 for exactly one cycle; mux_2_sel=1 for ld, 0 otherwise; pc_en=1, pc_sel=0; next FETCH.
REQ-012 rf_write_en SHALL be suppressed when rd == 0.
REQ-013 Latency: beq 3 cycles, R-type/addi/sd 4 cycles, ld 5 cycles, FETCH to next FETCH.
REQ-014 pc_en SHALL be high exactly once per retired instruction; never in FETCH, DECODE or TRAP.
REQ-015 TRAP: trap=1; all strobes (ir_load, pc_en, rf_write_en, dm_write_en) low; stays in TRAP until rst.
REQ-016 Strobes and selects SHALL be Moore outputs decoded from state and latched IR, except pc_sel in EXECUTE, which follows alu_zero combinationally.

Reset
REQ-017 rst=1 SHALL immediately, without a clock edge, force state=FETCH, IR=0, and all outputs 0 except ir_load=1 while state is FETCH.
REQ-018 rst asserted mid-instruction SHALL abort it with no write strobe issued after assertion; the first rising edge after deassertion executes FETCH.

Verification
REQ-019 addi x1,x0,5 (0x00500093) -> states FETCH, DECODE, EXECUTE, WRITEBACK; immediate=5; rf_write_addr=1; rf_write_en one cycle; pc_en once, pc_sel=0.
REQ-020 add x3,x1,x2 (0x002081B3) -> mux_1_sel=1, alu_operation=000, rf_addr_a=1, rf_addr_b=2, write to x3 in WRITEBACK; 4 cycles total.
REQ-021 ld x5,8(x2) (0x00813283) then sd x5,16(x2) (0x00513823) -> ld 5 cycles, mux_2_sel=1 in WRITEBACK; sd dm_write_en one cycle in MEMORY, immediate=16, no rf_write_en.
REQ-022 beq x1,x2,-8 (0xFE208CE3) with alu_zero=1 -> immediate=0xFFFFFFFFFFFFFFF8, pc_sel=1, pc_en in EXECUTE; repeat with alu_zero=0 -> pc_sel=0; 3 cycles each.
REQ-023 Illegal 0xFFFFFFFF -> TRAP after DECODE, trap=1, no strobes for 10 cycles; then addi x0,x0,1 (0x00100013) after rst -> rf_write_en stays 0 (rd=0).
REQ-024 rst pulsed asynchronously during MEMORY of sd -> dm_write_en drops immediately, state=FETCH, trap=0.
